dff_pipeline: RTL
=================

# dff_pipeline

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit edge-triggered registers with a per-stage valid bit and valid/ready handshake at both ends. Generalises the single-bit D flip-flop with asynchronous reset into a multi-bit, multi-stage, back-pressure-aware retiming block. Used between datapath units wherever a fixed register delay with stall support and bubble collapsing is needed.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of register stages (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all stage state
- in_valid  input  1  upstream presents in_data
- in_ready  output  1  pipeline accepts in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  last-stage data
- occupancy  output  $clog2(DEPTH+1)  number of valid stages
- flush  input  1  synchronous clear (present only with DFF_PIPELINE_FLUSH_EN)

## Operation
- Stage i holds valid_i and data_i; stage 0 fed by in_*, stage DEPTH-1 drives out_*.
- ready_DEPTH = out_ready; ready_i = !valid_i || ready_(i+1); in_ready = ready_0 (combinational chain, bubble collapsing).
- On edge, if ready_i: valid_i <= valid_(i-1) (in_valid for i=0); data_i <= data_(i-1) only when incoming valid is 1, else data_i holds.
- If !ready_i: stage i holds valid and data unchanged (stall).
- Transfer at input: in_valid && in_ready; at output: out_valid && out_ready. Data order strictly preserved; no drop, no duplication.
- occupancy = popcount of valid_0..valid_(DEPTH-1), registered alongside stages (updated each edge).
- in_valid must stay high with stable in_data until accepted; out side follows same rule toward downstream.
- Full: all valid and out_ready=0 → in_ready=0. Full with out_ready=1 → in_ready=1, whole pipe advances in one cycle.
- Empty pipeline, out_ready=0: data still advances to last stage, then stalls.

## Timing
- Reset (reset=0, any time, independent of clk): all valid_i=0, data_i=0; out_valid=0, out_data=0, occupancy=0, in_ready=1 while reset deasserted with empty pipe.
- Reset mid-operation discards all in-flight data; first accept after release behaves as from empty.
- Latency: item accepted at edge k reaches last stage at edge k+DEPTH-1 (out_valid high in following cycle) when unstalled; DEPTH=1 gives one-edge latency.
- Throughput: one item per cycle with out_ready held high.
- in_ready depends combinationally on out_ready (no register break); path length grows with DEPTH.
- out_data/out_valid are register outputs, no combinational path from inputs.

## Configuration
- DFF_PIPELINE_FLUSH_EN defined: flush port exists; flush=1 at an edge clears every valid_i and occupancy to 0 (data regs hold); in_ready forced 0 while flush=1, so no input accepted that cycle; out_valid still reflects pre-edge state (downstream may consume it).
- Undefined: no flush port; pipeline clears only via reset.

## Structure
- Shared package dff_pipeline_pkg: occupancy width function (clog2 of DEPTH+1), default WIDTH/DEPTH constants, stage record typedef {valid, data}.
- Sub-module dff_pipeline_stage: one valid+data register with async active-low reset, load enable, ready_in/ready_out; top generates DEPTH instances and the popcount.

## Test plan
- Reset then stream 0x01..0x0A, out_ready=1, DEPTH=4 → out_data 0x01..0x0A in order, first out_valid 4 cycles after first accept, one per cycle, occupancy steady at 4.
- Fill with out_ready=0 → after 4 accepts in_ready=0, occupancy=4, out_data=0x01; raise out_ready → in_ready=1 same cycle, no loss.
- Bubbles: in_valid every other cycle, out_ready toggling random → output sequence equals input sequence, occupancy never exceeds DEPTH.
- Assert reset with occupancy=3 → out_valid=0, out_data=0, occupancy=0 immediately, no old data emerges afterward.
- DEPTH=1, WIDTH=1: accept 1 then 0 with out_ready=1 → out_data 1 then 0, one-edge latency.
- With DFF_PIPELINE_FLUSH_EN: occupancy=4, pulse flush with in_valid=1 → next cycle occupancy=0, out_valid=0, flushed-cycle input not accepted.

Source files
------------

// File: rtl/dff_pipeline_pkg.sv
// Shared types and sizing helpers for the dff_pipeline elastic register pipeline.
// Optional synchronous flush is enabled by defining DFF_PIPELINE_FLUSH_EN.
package dff_pipeline_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
  } stageRec_t;

  // Occupancy must be able to represent every count from 0 up to and including DEPTH.
  function automatic int occWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipeline_if.sv
// Valid/ready handshake bundle for dff_pipeline: input side, output side and occupancy.
// The flush signal exists only when DFF_PIPELINE_FLUSH_EN is defined.
interface dff_pipeline_if
  import dff_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic [occWidth(DEPTH)-1:0]  occupancy;
`ifdef DFF_PIPELINE_FLUSH_EN
  logic                        flush;
`endif

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
`ifdef DFF_PIPELINE_FLUSH_EN
    output flush,
`endif
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
`ifdef DFF_PIPELINE_FLUSH_EN
    input  flush,
`endif
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );

endinterface

// File: rtl/dff_pipeline_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit data register with
// asynchronous active-low reset, a synchronous clear and a valid/ready handshake.
module dff_pipeline_stage
  import dff_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             validNext_o
);

  logic             valid_d;
  logic             valid_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // An empty stage can always take a new item, which is what collapses bubbles.
  assign ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign validNext_o = valid_d;

endmodule

// File: rtl/dff_pipeline.sv
// Top of the elastic register pipeline: DEPTH chained stages with a registered occupancy count.
// Define DFF_PIPELINE_FLUSH_EN to add the synchronous flush input on the interface.
module dff_pipeline
  import dff_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  dff_pipeline_if.slave      bus
);

  localparam int OCC_W = occWidth(DEPTH);

  logic [DEPTH:0]   stageReady;
  logic [DEPTH-1:0] stageValid;
  logic [DEPTH-1:0] validNext;
  logic [WIDTH-1:0] stageData [DEPTH];
  logic             flushNow;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_q;

`ifdef DFF_PIPELINE_FLUSH_EN
  assign flushNow = bus.flush;
`else
  assign flushNow = 1'b0;
`endif

  assign stageReady[DEPTH] = bus.out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : gStage
    logic             vIn;
    logic [WIDTH-1:0] dIn;

    if (g == 0) begin : gHead
      assign vIn = bus.in_valid;
      assign dIn = bus.in_data;
    end else begin : gBody
      assign vIn = stageValid[g-1];
      assign dIn = stageData[g-1];
    end

    dff_pipeline_stage #(
      .WIDTH(WIDTH)
    ) uStage (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (flushNow),
      .valid_i     (vIn),
      .data_i      (dIn),
      .ready_i     (stageReady[g+1]),
      .ready_o     (stageReady[g]),
      .valid_o     (stageValid[g]),
      .data_o      (stageData[g]),
      .validNext_o (validNext[g])
    );
  end

  // Count the post-edge valid bits so the registered total lines up with the stages.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(validNext[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.in_ready  = stageReady[0] && !flushNow;
  assign bus.out_valid = stageValid[DEPTH-1];
  assign bus.out_data  = stageData[DEPTH-1];
  assign bus.occupancy = occ_q;

endmodule
